layer_capture: RTL

- Write-side counterpart of the layer_blend read path. Takes one incoming YCbCr video stream (i_hs/i_vs/i_de + 24-bit data, e.g. a decoded CVBS channel) and crops a window from it.
- Optionally decimates the window 2:1 horizontally and/or vertically.
- Pushes the surviving pixels into the layer FIFO/frame-buffer writer through a wrreq/wrfull handshake.
- Four instances, one per layer, feed the layer0..3 ycbcr sources consumed by the display pipeline.

---
 rtl/layer_capture_pkg.sv | 32 +++
 rtl/capture_xy_counter.sv | 58 +++++
 rtl/layer_capture.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/layer_capture_pkg.sv
// Shared definitions for the layer capture write path: pixel layout,
// coordinate width and the capture state encoding.
package layer_capture_pkg;

  // Pixel is packed {Y, Cb, Cr}, 8 bits each, Y in the top byte
  localparam int PIX_DW  = 24;
  localparam int COORD_W = 12;

  localparam int Y_MSB  = 23;
  localparam int Y_LSB  = 16;
  localparam int CB_MSB = 15;
  localparam int CB_LSB = 8;
  localparam int CR_MSB = 7;
  localparam int CR_LSB = 0;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycbcr_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_t;

  function automatic logic [7:0] luma_of(input logic [PIX_DW-1:0] pix);
    return pix[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/capture_xy_counter.sv
// Edge detection on the incoming vsync / data-enable and the x/y position
// counters of the current pixel. The pixel presented while de first rises
// sits at x = 0; the first line after a vsync rising edge sits at y = 0.
module capture_xy_counter
  import layer_capture_pkg::*;
#(
  parameter int CW = COORD_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vs,
  input  logic          i_de,
  output logic          vs_rise,
  output logic          de_fall,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y
);

  logic vs_d;
  logic de_d;

  // One register stage on vsync and de for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
    end else begin
      vs_d <= i_vs;
      de_d <= i_de;
    end
  end

  assign vs_rise = i_vs & ~vs_d;
  assign de_fall = ~i_de & de_d;

  // Column counter: counts active pixels, restarts at the end of each line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
    end else if (de_fall) begin
      x <= '0;
    end else if (i_de) begin
      x <= x + 1'b1;
    end
  end

  // Line counter: counts completed lines, restarts at each frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (vs_rise) begin
      y <= '0;
    end else if (de_fall) begin
      y <= y + 1'b1;
    end
  end

endmodule

// File: rtl/layer_capture.sv
// Captures a cropped, optionally 2:1 decimated window of an incoming YCbCr
// stream and pushes it into a layer FIFO through a wrreq/wrfull handshake.
// Capture is armed by 'enable' and always begins and ends on whole frames.
module layer_capture
  import layer_capture_pkg::*;
#(
  parameter int DW = PIX_DW,
  parameter int CW = COORD_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          i_hs,
  input  logic          i_vs,
  input  logic          i_de,
  input  logic [DW-1:0] i_ycbcr,
  input  logic [CW-1:0] crop_left,
  input  logic [CW-1:0] crop_top,
  input  logic [CW-1:0] crop_width,
  input  logic [CW-1:0] crop_height,
  input  logic          h_decim,
  input  logic          v_decim,
  input  logic          wrfull,
  input  logic          ovf_clr,
  output logic          wrreq,
  output logic [DW-1:0] wrdata,
  output logic          frame_start,
  output logic          frame_done,
  output logic          overflow,
  output logic          busy
);

  cap_state_t state;

  logic          vs_rise;
  logic          de_fall;
  logic [CW-1:0] x;
  logic [CW-1:0] y;

  logic [CW-1:0] sh_left;
  logic [CW-1:0] sh_top;
  logic [CW-1:0] sh_width;
  logic [CW-1:0] sh_height;
  logic          sh_hdecim;
  logic          sh_vdecim;

  logic [CW:0]   x_end;
  logic [CW:0]   y_end;
  logic          in_x;
  logic          in_y;
  logic          keep_x;
  logic          keep_y;
  logic          in_window;
  logic          capturing;
  logic          do_write;
  logic          do_drop;

  // hsync travels with the stream but plays no part in positioning
  logic          unused_hs;
  assign unused_hs = i_hs;

  capture_xy_counter #(
    .CW (CW)
  ) u_xy (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_vs    (i_vs),
    .i_de    (i_de),
    .vs_rise (vs_rise),
    .de_fall (de_fall),
    .x       (x),
    .y       (y)
  );

  // Crop and decimation settings are frozen at each frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_left   <= '0;
      sh_top    <= '0;
      sh_width  <= '0;
      sh_height <= '0;
      sh_hdecim <= 1'b0;
      sh_vdecim <= 1'b0;
    end else if (vs_rise) begin
      sh_left   <= crop_left;
      sh_top    <= crop_top;
      sh_width  <= crop_width;
      sh_height <= crop_height;
      sh_hdecim <= h_decim;
      sh_vdecim <= v_decim;
    end
  end

  // Window ends are computed one bit wider so a window near the top of the
  // coordinate range does not wrap around to small x / y values.
  assign x_end = {1'b0, sh_left} + {1'b0, sh_width};
  assign y_end = {1'b0, sh_top}  + {1'b0, sh_height};

  assign in_x = (x >= sh_left) && ({1'b0, x} < x_end);
  assign in_y = (y >= sh_top)  && ({1'b0, y} < y_end);

  // The LSB of (pos - origin) equals pos[0] ^ origin[0], so even window
  // offsets are found without a full subtractor.
  assign keep_x = ~sh_hdecim | ~(x[0] ^ sh_left[0]);
  assign keep_y = ~sh_vdecim | ~(y[0] ^ sh_top[0]);

  assign in_window = i_de & in_x & in_y & keep_x & keep_y;
  assign capturing = (state == ST_CAPTURE);
  assign do_write  = capturing & in_window & ~wrfull;
  assign do_drop   = capturing & in_window &  wrfull;
  assign busy      = capturing;

  // Frame-level sequencing: arm on enable, start and stop only on vsync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (vs_rise) begin
            state       <= ST_CAPTURE;
            frame_start <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (vs_rise) begin
            frame_done <= 1'b1;
            if (enable) begin
              frame_start <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered write strobe and data, one clock behind the input pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrreq  <= 1'b0;
      wrdata <= '0;
    end else begin
      wrreq <= do_write;
      if (do_write) begin
        wrdata <= i_ycbcr;
      end
    end
  end

  // Sticky drop flag; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else begin
      overflow <= (overflow & ~ovf_clr) | do_drop;
    end
  end

endmodule
